pico_bus_fabric: RTL

- Parametrised N-slave interconnect for the PicoRV32 native memory bus; replaces hand-written address compares and ready/rdata mux chains in SoC tops.
- Decodes each master request against base/mask windows, forwards it to exactly one slave, and registers the response.
- Terminates unmapped and hung accesses with an error word, a sticky IRQ and a captured fault address.

---
 rtl/pico_bus_fabric_if.sv | 34 +++
 rtl/pico_bus_fabric.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pico_bus_fabric_if.sv
// PicoRV32 native bus bundle: the CPU-facing request/response pair plus the
// shared slave-side request and the per-slave ready/rdata return.
interface pico_bus_fabric_if #(
  parameter int NSLAVES = 4
) ();
  logic                   m_valid;
  logic                   m_ready;
  logic [31:0]            m_addr;
  logic [31:0]            m_wdata;
  logic [3:0]             m_wstrb;
  logic [31:0]            m_rdata;

  logic [NSLAVES-1:0]     s_valid;
  logic [NSLAVES-1:0]     s_ready;
  logic [NSLAVES*32-1:0]  s_rdata;
  logic [31:0]            s_addr;
  logic [31:0]            s_wdata;
  logic [3:0]             s_wstrb;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata
  );

  modport slave (
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

  modport fabric (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/pico_bus_fabric.sv
// N-slave base/mask decoder for the PicoRV32 native bus with registered
// response, timeout abort and a sticky first-fault capture.
module pico_bus_fabric #(
  parameter int                      NSLAVES    = 4,
  parameter logic [NSLAVES*32-1:0]   SLAVE_BASE = {32'h0300_0000, 32'h0200_0000,
                                                   32'h0002_0000, 32'h0000_0000},
  parameter logic [NSLAVES*32-1:0]   SLAVE_MASK = {32'hFF00_0000, 32'hFFFF_FFF0,
                                                   32'hFFFF_C000, 32'hFFFF_C000},
  parameter int                      TIMEOUT    = 255,
  parameter logic [31:0]             ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  pico_bus_fabric_if.fabric     bus,
  output logic                  err_irq,
  output logic [31:0]           err_addr,
  input  logic                  err_clear
);

  localparam int          SW     = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam logic [31:0] TLIMIT = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t               state_reg;
  logic                 m_ready_reg;
  logic [31:0]          m_rdata_reg;
  logic [NSLAVES-1:0]   s_valid_reg;
  logic [31:0]          s_addr_reg;
  logic [31:0]          s_wdata_reg;
  logic [3:0]           s_wstrb_reg;
  logic [SW-1:0]        sel_reg;
  logic [31:0]          timer_reg;
  logic                 err_irq_reg;
  logic [31:0]          err_addr_reg;

  logic [NSLAVES-1:0]   hit;
  logic                 hit_any;
  logic [NSLAVES-1:0]   sel_onehot;
  logic [SW-1:0]        sel_next;
  logic [31:0]          s_rdata_arr [NSLAVES];
  logic                 sel_ready;
  logic                 timed_out;
  logic                 err_event;
  logic [31:0]          err_src_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NSLAVES; gi++) begin : g_slave
      assign hit[gi]         = ((bus.m_addr & SLAVE_MASK[gi*32 +: 32]) == SLAVE_BASE[gi*32 +: 32]);
      assign s_rdata_arr[gi] = bus.s_rdata[gi*32 +: 32];
    end
  endgenerate

  // Walk from the top index down so the lowest matching window is the last write.
  always_comb begin
    hit_any    = |hit;
    sel_onehot = '0;
    sel_next   = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        sel_next      = SW'(i);
      end
    end
  end

  // s_valid_reg is one-hot during ACTIVE, so this only sees the selected slave.
  assign sel_ready = |(bus.s_ready & s_valid_reg);
  assign timed_out = (TIMEOUT != 0) && (timer_reg == TLIMIT);

  assign err_event = ((state_reg == IDLE) && bus.m_valid && !hit_any) ||
                     ((state_reg == ACTIVE) && !sel_ready && timed_out);
  // An unmapped fault is raised on the same edge that latches s_addr.
  assign err_src_addr = (state_reg == IDLE) ? bus.m_addr : s_addr_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      m_ready_reg <= 1'b0;
      m_rdata_reg <= '0;
      s_valid_reg <= '0;
      s_addr_reg  <= '0;
      s_wdata_reg <= '0;
      s_wstrb_reg <= '0;
      sel_reg     <= '0;
      timer_reg   <= '0;
    end else begin
      m_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.m_valid) begin
            s_addr_reg  <= bus.m_addr;
            s_wdata_reg <= bus.m_wdata;
            s_wstrb_reg <= bus.m_wstrb;
            sel_reg     <= sel_next;
            timer_reg   <= '0;
            if (hit_any) begin
              s_valid_reg <= sel_onehot;
              state_reg   <= ACTIVE;
            end else begin
              m_rdata_reg <= ERR_DATA;
              m_ready_reg <= 1'b1;
              state_reg   <= RESP;
            end
          end
        end
        ACTIVE: begin
          timer_reg <= timer_reg + 32'd1;
          if (sel_ready) begin
            m_rdata_reg <= s_rdata_arr[sel_reg];
            s_valid_reg <= '0;
            m_ready_reg <= 1'b1;
            state_reg   <= RESP;
          end else if (timed_out) begin
            m_rdata_reg <= ERR_DATA;
            s_valid_reg <= '0;
            m_ready_reg <= 1'b1;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          timer_reg <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A fault in the same cycle as err_clear must survive, with its own address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_irq_reg  <= 1'b0;
      err_addr_reg <= '0;
    end else if (err_event) begin
      err_irq_reg <= 1'b1;
      if (!err_irq_reg || err_clear) begin
        err_addr_reg <= err_src_addr;
      end
    end else if (err_clear) begin
      err_irq_reg  <= 1'b0;
      err_addr_reg <= '0;
    end
  end

  assign bus.m_ready = m_ready_reg;
  assign bus.m_rdata = m_rdata_reg;
  assign bus.s_valid = s_valid_reg;
  assign bus.s_addr  = s_addr_reg;
  assign bus.s_wdata = s_wdata_reg;
  assign bus.s_wstrb = s_wstrb_reg;
  assign err_irq     = err_irq_reg;
  assign err_addr    = err_addr_reg;

endmodule
